// File: rtl/am_mem_pkg.sv
// ---------------------------------------------------------------------------
// am_mem_pkg
// Shared widths and state encoding for the accumulator-machine memory
// responder (am_mem) and its RAM macro (am_ram).
//   AM_OPCODE_W : opcode field width of an instruction word
//   AM_ADDR_W   : address width, each memory holds 2**AM_ADDR_W words
//   AM_DATA_W   : data word width
//   AM_IW_W     : instruction word width, {opcode, operand}
//   am_state_e  : loader/run state of the responder
// ---------------------------------------------------------------------------
package am_mem_pkg;

    localparam int AM_OPCODE_W = 4;
    localparam int AM_ADDR_W   = 8;
    localparam int AM_DATA_W   = 8;
    localparam int AM_IW_W     = AM_OPCODE_W + AM_ADDR_W;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } am_state_e;

endpackage

// File: rtl/am_ram.sv
// ---------------------------------------------------------------------------
// am_ram
// Single-port-write, asynchronous-read RAM. Contents are not reset.
//   clk   : clock
//   we    : write enable, write happens at the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr (old data until the write edge)
// ---------------------------------------------------------------------------
module am_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/am_mem.sv
// ---------------------------------------------------------------------------
// am_mem
// Instruction/data memory responder and program loader for the accumulator
// machine core. A valid/ready word stream fills imem and dmem while the core
// is held in reset; the word flagged ld_last releases the core.
//   clk, rst   : clock, synchronous active-high reset
//   pcout      : core fetch address
//   we, accum  : core data write enable and write data (honoured in RUN only)
//   opcode     : imem[pcout] upper field
//   operand    : imem[pcout] lower field, also the dmem address
//   ddatain    : dmem[operand]
//   cpu_rst_n  : core reset, active-low, released on the last loaded word
//   ld_start   : restart loading from address 0 in both memories
//   ld_valid   : loader word valid
//   ld_ready   : loader can accept a word (high in LOAD)
//   ld_tgt     : 0 -> imem, 1 -> dmem
//   ld_data    : loader word, dmem takes the low DATA_W bits
//   ld_last    : final word of the image
//   ld_ovf     : sticky, an address counter wrapped during load
// ---------------------------------------------------------------------------
module am_mem
    import am_mem_pkg::*;
#(
    parameter int OPCODE_W = AM_OPCODE_W,
    parameter int ADDR_W   = AM_ADDR_W,
    parameter int DATA_W   = AM_DATA_W,
    parameter int IW_W     = OPCODE_W + ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pcout,
    input  logic                we,
    input  logic [DATA_W-1:0]   accum,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   operand,
    output logic [DATA_W-1:0]   ddatain,
    output logic                cpu_rst_n,
    input  logic                ld_start,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic                ld_tgt,
    input  logic [IW_W-1:0]     ld_data,
    input  logic                ld_last,
    output logic                ld_ovf
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    am_state_e         state_q, state_d;
    logic [ADDR_W-1:0] i_cnt_q, i_cnt_d;
    logic [ADDR_W-1:0] d_cnt_q, d_cnt_d;
    logic              ld_ovf_q, ld_ovf_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              ld_ready_q, ld_ready_d;

    logic              accept;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [IW_W-1:0]   imem_rdata;

    assign accept = ld_valid & ld_ready_q;

    // Next-state, counter and memory-write decode. Priority is
    // rst > ld_start > loader accept / core write, so a restart drops any
    // word or store presented in the same cycle.
    always_comb begin
        state_d    = state_q;
        i_cnt_d    = i_cnt_q;
        d_cnt_d    = d_cnt_q;
        ld_ovf_d   = ld_ovf_q;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = d_cnt_q;
        dmem_wdata = ld_data[DATA_W-1:0];

        if (ld_start) begin
            state_d  = ST_LOAD;
            i_cnt_d  = '0;
            d_cnt_d  = '0;
            ld_ovf_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (accept) begin
                if (!ld_tgt) begin
                    imem_we = 1'b1;
                    i_cnt_d = i_cnt_q + ADDR_W'(1);
                    if (i_cnt_q == ADDR_MAX && !ld_last) begin
                        ld_ovf_d = 1'b1;
                    end
                end else begin
                    dmem_we = 1'b1;
                    d_cnt_d = d_cnt_q + ADDR_W'(1);
                    if (d_cnt_q == ADDR_MAX && !ld_last) begin
                        ld_ovf_d = 1'b1;
                    end
                end
                if (ld_last) begin
                    state_d = ST_RUN;
                end
            end
        end else if (we) begin
            dmem_we    = 1'b1;
            dmem_waddr = operand;
            dmem_wdata = accum;
        end

        // Reset leaves memory contents alone, including any word offered
        // during the reset cycle.
        if (rst) begin
            imem_we = 1'b0;
            dmem_we = 1'b0;
        end

        ld_ready_d  = (state_d == ST_LOAD);
        cpu_rst_n_d = (state_d == ST_RUN);
    end

    // State, counters and registered handshake/reset outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
            ld_ovf_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            i_cnt_q     <= i_cnt_d;
            d_cnt_q     <= d_cnt_d;
            ld_ovf_q    <= ld_ovf_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    am_ram #(
        .AW(ADDR_W),
        .DW(IW_W)
    ) imem (
        .clk  (clk),
        .we   (imem_we),
        .waddr(i_cnt_q),
        .wdata(ld_data),
        .raddr(pcout),
        .rdata(imem_rdata)
    );

    am_ram #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) dmem (
        .clk  (clk),
        .we   (dmem_we),
        .waddr(dmem_waddr),
        .wdata(dmem_wdata),
        .raddr(operand),
        .rdata(ddatain)
    );

    assign opcode    = imem_rdata[IW_W-1:ADDR_W];
    assign operand   = imem_rdata[ADDR_W-1:0];
    assign cpu_rst_n = cpu_rst_n_q;
    assign ld_ready  = ld_ready_q;
    assign ld_ovf    = ld_ovf_q;

endmodule

// File: tb/tb_am_mem.sv
// ---------------------------------------------------------------------------
// tb_am_mem
// Self-checking bench for am_mem. A behavioural model (plain arrays plus a
// run flag and two integer fill pointers) is advanced once per clock from the
// same inputs given to the DUT; after every edge all visible outputs are
// compared against it. Directed scenarios are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_am_mem;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int IW = OW + AW;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pcout;
    logic          we;
    logic [DW-1:0] accum;
    logic [OW-1:0] opcode;
    logic [AW-1:0] operand;
    logic [DW-1:0] ddatain;
    logic          cpu_rst_n;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic          ld_tgt;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ovf;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model
    logic [IW-1:0] imemModel [DEPTH];
    logic [DW-1:0] dmemModel [DEPTH];
    bit            imemKnown [DEPTH];
    bit            dmemKnown [DEPTH];
    bit            modelRun;
    bit            modelOvf;
    int            modelIPtr;
    int            modelDPtr;

    am_mem dut (
        .clk      (clk),
        .rst      (rst),
        .pcout    (pcout),
        .we       (we),
        .accum    (accum),
        .opcode   (opcode),
        .operand  (operand),
        .ddatain  (ddatain),
        .cpu_rst_n(cpu_rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_tgt   (ld_tgt),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ovf   (ld_ovf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock from the currently driven inputs.
    task automatic modelStep();
        logic [AW-1:0] waddr;
        if (rst || ld_start) begin
            modelRun  = 1'b0;
            modelOvf  = 1'b0;
            modelIPtr = 0;
            modelDPtr = 0;
        end else if (!modelRun) begin
            if (ld_valid) begin
                if (!ld_tgt) begin
                    imemModel[modelIPtr] = ld_data;
                    imemKnown[modelIPtr] = 1'b1;
                    if (modelIPtr == DEPTH - 1 && !ld_last) modelOvf = 1'b1;
                    modelIPtr = (modelIPtr + 1) % DEPTH;
                end else begin
                    dmemModel[modelDPtr] = ld_data[DW-1:0];
                    dmemKnown[modelDPtr] = 1'b1;
                    if (modelDPtr == DEPTH - 1 && !ld_last) modelOvf = 1'b1;
                    modelDPtr = (modelDPtr + 1) % DEPTH;
                end
                if (ld_last) modelRun = 1'b1;
            end
        end else if (we && imemKnown[pcout]) begin
            waddr = imemModel[pcout][AW-1:0];
            dmemModel[waddr] = accum;
            dmemKnown[waddr] = 1'b1;
        end
    endtask

    // Compare every output with the model after an edge.
    task automatic checkAll();
        logic [AW-1:0] expOperand;
        checkOutput("cpu_rst_n", 32'(cpu_rst_n), 32'(modelRun));
        checkOutput("ld_ready", 32'(ld_ready), 32'(!modelRun));
        checkOutput("ld_ovf", 32'(ld_ovf), 32'(modelOvf));
        if (imemKnown[pcout]) begin
            expOperand = imemModel[pcout][AW-1:0];
            checkOutput("opcode", 32'(opcode), 32'(imemModel[pcout][IW-1:AW]));
            checkOutput("operand", 32'(operand), 32'(expOperand));
            if (dmemKnown[expOperand]) begin
                checkOutput("ddatain", 32'(ddatain), 32'(dmemModel[expOperand]));
            end
        end
    endtask

    // Drive one cycle of inputs, update the model, clock, then check.
    task automatic applyStimulus(input logic r, input logic start,
                                 input logic valid, input logic tgt,
                                 input logic [IW-1:0] data, input logic last,
                                 input logic [AW-1:0] pc, input logic w,
                                 input logic [DW-1:0] acc);
        @(negedge clk);
        rst      = r;
        ld_start = start;
        ld_valid = valid;
        ld_tgt   = tgt;
        ld_data  = data;
        ld_last  = last;
        pcout    = pc;
        we       = w;
        accum    = acc;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input logic [AW-1:0] pc);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, pc, 1'b0, '0);
    endtask

    task automatic loadWord(input logic tgt, input logic [IW-1:0] data,
                            input logic last);
        applyStimulus(1'b0, 1'b0, 1'b1, tgt, data, last, '0, 1'b0, '0);
    endtask

    initial begin
        logic [IW-1:0] word;
        logic [IW-1:0] firstWord;
        logic [IW-1:0] wrapWord;
        int            sent;
        int            budget;
        logic [AW-1:0] pc;
        logic          w;

        for (int i = 0; i < DEPTH; i++) begin
            imemKnown[i] = 1'b0;
            dmemKnown[i] = 1'b0;
        end
        modelRun = 1'b0; modelOvf = 1'b0; modelIPtr = 0; modelDPtr = 0;
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_tgt = 1'b0;
        ld_data = '0; ld_last = 1'b0; pcout = '0; we = 1'b0; accum = '0;

        // Reset for two cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        checkOutput("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("reset_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("reset_ld_ovf", 32'(ld_ovf), 32'd0);

        // Small image: three instructions, two data words, last on dmem.
        loadWord(1'b0, {4'h1, 8'h10}, 1'b0);
        loadWord(1'b0, {4'h2, 8'h11}, 1'b0);
        loadWord(1'b0, {4'h3, 8'h03}, 1'b0);
        loadWord(1'b1, 12'h005, 1'b0);
        checkOutput("cpu_held_in_load", 32'(cpu_rst_n), 32'd0);
        loadWord(1'b1, 12'h007, 1'b1);
        checkOutput("cpu_released_last", 32'(cpu_rst_n), 32'd1);
        checkOutput("ready_dropped_last", 32'(ld_ready), 32'd0);
        idle(8'd1);
        checkOutput("fetch1_opcode", 32'(opcode), 32'h2);
        checkOutput("fetch1_operand", 32'(operand), 32'h11);
        idle(8'd0);
        checkOutput("fetch0_operand", 32'(operand), 32'h10);

        // Core store in RUN: imem[2] has operand 3.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd2, 1'b1, 8'hA5);
        checkOutput("store_ddatain", 32'(ddatain), 32'hA5);
        checkOutput("store_operand", 32'(operand), 32'h03);

        // Store attempted while loading is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 8'd2, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 8'd2, 1'b1, 8'h5A);
        checkOutput("load_we_ignored", 32'(ddatain), 32'hA5);

        // 257 imem words with random stalls; counter wraps after word 255.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        sent = 0;
        budget = 0;
        firstWord = '0;
        while (sent < DEPTH + 1 && budget < 2000) begin
            budget++;
            word = IW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, word, 1'b0, '0, 1'b0, '0);
            end else begin
                if (sent == 0) firstWord = word;
                if (sent == DEPTH) wrapWord = word;
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, word, 1'b0, '0, 1'b0, '0);
                sent++;
                if (sent == DEPTH - 1) checkOutput("ovf_before_255", 32'(ld_ovf), 32'd0);
                if (sent == DEPTH) checkOutput("ovf_after_255", 32'(ld_ovf), 32'd1);
            end
        end
        checkOutput("wrap_budget", 32'(sent), 32'(DEPTH + 1));
        idle(8'd0);
        checkOutput("wrap_overwrite", 32'({opcode, operand}), 32'(wrapWord));
        checkOutput("wrap_changed", 32'({opcode, operand} == firstWord), 32'(wrapWord == firstWord));

        // Finish the image so the core runs again.
        loadWord(1'b1, 12'h0C3, 1'b1);

        // Restart beats a same-cycle word and store.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'hFEE, 1'b0, 8'd0, 1'b1, 8'h66);
        checkOutput("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("restart_ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("restart_ovf_clear", 32'(ld_ovf), 32'd0);
        checkOutput("restart_word_dropped", 32'({opcode, operand}), 32'(wrapWord));
        loadWord(1'b0, 12'h9AB, 1'b0);
        idle(8'd0);
        checkOutput("restart_cnt_zero", 32'({opcode, operand}), 32'h9AB);

        // Reset in the middle of a load keeps the partial image.
        loadWord(1'b0, 12'h421, 1'b0);
        loadWord(1'b0, 12'h532, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'hDDD, 1'b0, 8'd1, 1'b0, '0);
        checkOutput("midrst_keep1", 32'({opcode, operand}), 32'h421);
        loadWord(1'b0, 12'h777, 1'b0);
        idle(8'd0);
        checkOutput("midrst_cnt_zero", 32'({opcode, operand}), 32'h777);
        idle(8'd2);
        checkOutput("midrst_keep2", 32'({opcode, operand}), 32'h532);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            pc = AW'($urandom);
            w  = 1'($urandom);
            if (!imemKnown[pc]) w = 1'b0;
            applyStimulus(($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 39) == 0),
                          1'($urandom),
                          1'($urandom),
                          IW'($urandom),
                          ($urandom_range(0, 15) == 0),
                          pc, w, DW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
